// File: rtl/acc_mem_arbiter_if.sv
// Accelerator request/response and Data Memory port bundle for acc_mem_arbiter.
// The arbiter uses the slave view; requesters and the memory use the master view.
interface acc_mem_arbiter_if #(
  parameter int NUM_ACC         = 2,
  parameter int ADDR_SIZE       = 16,
  parameter int READ_DATA_SIZE  = 512,
  parameter int WRITE_DATA_SIZE = 32
);
  logic                               cpu_mem_busy;
  logic [NUM_ACC-1:0]                 acc_read_en;
  logic [NUM_ACC*ADDR_SIZE-1:0]       acc_read_addr;
  logic [NUM_ACC-1:0]                 acc_write_en;
  logic [NUM_ACC*ADDR_SIZE-1:0]       acc_write_addr;
  logic [NUM_ACC*WRITE_DATA_SIZE-1:0] acc_write_data;
  logic [READ_DATA_SIZE-1:0]          acc_read_data;
  logic [NUM_ACC-1:0]                 acc_read_data_valid;
  logic [NUM_ACC-1:0]                 acc_write_done;
  logic [ADDR_SIZE-1:0]               mem_addr;
  logic                               mem_rd_en;
  logic                               mem_wr_en;
  logic [WRITE_DATA_SIZE-1:0]         mem_wr_data;
  logic [READ_DATA_SIZE-1:0]          mem_rd_data;
  logic                               busy;

  modport slave (
    input  cpu_mem_busy, acc_read_en, acc_read_addr, acc_write_en,
           acc_write_addr, acc_write_data, mem_rd_data,
    output acc_read_data, acc_read_data_valid, acc_write_done,
           mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, busy
  );

  modport master (
    output cpu_mem_busy, acc_read_en, acc_read_addr, acc_write_en,
           acc_write_addr, acc_write_data, mem_rd_data,
    input  acc_read_data, acc_read_data_valid, acc_write_done,
           mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, busy
  );
endinterface

// File: rtl/acc_mem_arbiter.sv
// Round-robin arbiter serializing accelerator read/write requests onto the shared
// Data Memory port, yielding to CPU traffic and pulsing done/valid to the requester.
module acc_mem_arbiter #(
  parameter int NUM_ACC          = 2,
  parameter int ADDR_SIZE        = 16,
  parameter int READ_DATA_SIZE   = 512,
  parameter int WRITE_DATA_SIZE  = 32,
  parameter int MEM_READ_LATENCY = 1
) (
  input logic              clk,
  input logic              rst,
  acc_mem_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int LAT_W = $clog2(MEM_READ_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                     state;
  logic [PTR_W-1:0]           sel_port;
  logic [PTR_W-1:0]           rr_ptr;
  logic [PTR_W-1:0]           grant_port;
  logic                       grant_found;
  logic                       sel_is_write;
  logic [ADDR_SIZE-1:0]       sel_addr;
  logic [WRITE_DATA_SIZE-1:0] sel_wdata;
  logic [LAT_W-1:0]           lat_cnt;
  logic [READ_DATA_SIZE-1:0]  rd_buf;
  logic [NUM_ACC-1:0]         pending;
  logic [NUM_ACC-1:0]         rd_valid_q;
  logic [NUM_ACC-1:0]         wr_done_q;
  logic                       issue_go;

  assign pending = bus.acc_read_en | bus.acc_write_en;

  // Scan downward so the pending port closest above rr_ptr wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_port  = '0;
    for (int k = NUM_ACC - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_ACC;
      if (pending[idx]) begin
        grant_found = 1'b1;
        grant_port  = PTR_W'(idx);
      end
    end
  end

  assign issue_go                = (state == ISSUE) && !bus.cpu_mem_busy;
  assign bus.mem_rd_en           = issue_go && !sel_is_write;
  assign bus.mem_wr_en           = issue_go && sel_is_write;
  assign bus.mem_addr            = issue_go ? sel_addr : '0;
  assign bus.mem_wr_data         = bus.mem_wr_en ? sel_wdata : '0;
  assign bus.acc_read_data       = rd_buf;
  assign bus.acc_read_data_valid = rd_valid_q;
  assign bus.acc_write_done      = wr_done_q;
  assign bus.busy                = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sel_port     <= '0;
      sel_is_write <= 1'b0;
      rr_ptr       <= '0;
      lat_cnt      <= '0;
      rd_buf       <= '0;
      rd_valid_q   <= '0;
      wr_done_q    <= '0;
    end else begin
      rd_valid_q <= '0;
      wr_done_q  <= '0;
      case (state)
        IDLE: begin
          if (!bus.cpu_mem_busy && grant_found) begin
            sel_port     <= grant_port;
            sel_is_write <= bus.acc_write_en[grant_port];
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (!bus.cpu_mem_busy) begin
            if (sel_is_write) begin
              wr_done_q[sel_port] <= 1'b1;
              state               <= RESP;
            end else begin
              lat_cnt <= LAT_W'(MEM_READ_LATENCY);
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LAT_W'(1)) begin
            rd_buf               <= bus.mem_rd_data;
            rd_valid_q[sel_port] <= 1'b1;
            state                <= RESP;
          end
        end
        RESP: begin
          rr_ptr <= (sel_port == PTR_W'(NUM_ACC - 1)) ? '0 : sel_port + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request payload is re-latched every IDLE cycle; the grant cycle's copy is the one issued.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      sel_addr  <= bus.acc_write_en[grant_port]
                   ? bus.acc_write_addr[grant_port*ADDR_SIZE +: ADDR_SIZE]
                   : bus.acc_read_addr[grant_port*ADDR_SIZE +: ADDR_SIZE];
      sel_wdata <= bus.acc_write_data[grant_port*WRITE_DATA_SIZE +: WRITE_DATA_SIZE];
    end
  end
endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Bench for acc_mem_arbiter: directed scenarios plus randomized requesters, CPU
// contention and resets, checked each cycle against a transaction-level model.
module tb_acc_mem_arbiter;
  localparam int N  = 2;
  localparam int AW = 16;
  localparam int RW = 512;
  localparam int WW = 32;
  localparam int L  = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acc_mem_arbiter_if #(.NUM_ACC(N), .ADDR_SIZE(AW), .READ_DATA_SIZE(RW),
                       .WRITE_DATA_SIZE(WW)) bus ();

  acc_mem_arbiter #(.NUM_ACC(N), .ADDR_SIZE(AW), .READ_DATA_SIZE(RW),
                    .WRITE_DATA_SIZE(WW), .MEM_READ_LATENCY(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // requester / CPU stimulus state
  logic [N-1:0]  rd_en, wr_en;
  logic [AW-1:0] rd_addr [N];
  logic [AW-1:0] wr_addr [N];
  logic [WW-1:0] wdata   [N];
  logic          cpu;
  logic [RW-1:0] mem_pipe [L];

  // per-cycle snapshot of DUT outputs
  logic          s_busy, s_rd_en, s_wr_en;
  logic [AW-1:0] s_addr;
  logic [WW-1:0] s_wdata;
  logic [N-1:0]  s_valid, s_done;
  logic [RW-1:0] s_rdata;

  // transaction-level reference model
  bit            m_active, m_issued, m_wr;
  int            m_port, m_rr, m_resp_at, cyc;
  logic [AW-1:0] m_addr;
  logic [WW-1:0] m_wdata;
  logic [RW-1:0] m_rdata;
  logic [N-1:0]  e_valid, e_done;

  task automatic check_eq(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] mem_pattern(input logic [AW-1:0] a);
    if (a == 16'h1010) return {64{8'hA5}};
    return {16{a, ~a}};
  endfunction

  function automatic logic [RW-1:0] rand_rw();
    logic [RW-1:0] r;
    for (int i = 0; i < RW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_inputs();
    bus.cpu_mem_busy = cpu;
    bus.acc_read_en  = rd_en;
    bus.acc_write_en = wr_en;
    for (int p = 0; p < N; p++) begin
      bus.acc_read_addr[p*AW +: AW]  = rd_addr[p];
      bus.acc_write_addr[p*AW +: AW] = wr_addr[p];
      bus.acc_write_data[p*WW +: WW] = wdata[p];
    end
    bus.mem_rd_data = mem_pipe[L-1];
  endtask

  task automatic model_step();
    logic          e_busy, e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic [WW-1:0] e_wd;
    bit            done_txn, granted;
    int            gp, p;
    e_busy = m_active; e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
    e_valid = '0; e_done = '0; done_txn = 0; granted = 0; gp = 0;
    if (!m_active) begin
      if (!cpu) begin
        for (int k = 0; k < N; k++) begin
          p = (m_rr + k) % N;
          if (!granted && (rd_en[p] || wr_en[p])) begin
            granted = 1; gp = p;
          end
        end
      end
    end else if (!m_issued) begin
      if (!cpu) begin
        e_addr = m_addr;
        if (m_wr) begin e_wr = 1'b1; e_wd = m_wdata; end
        else e_rd = 1'b1;
        m_issued  = 1;
        m_resp_at = cyc + (m_wr ? 1 : 1 + L);
      end
    end else if (cyc == m_resp_at) begin
      if (m_wr) e_done[m_port] = 1'b1;
      else begin
        e_valid[m_port] = 1'b1;
        m_rdata = mem_pattern(m_addr);
      end
      done_txn = 1;
    end
    check_eq("busy",        RW'(s_busy),  RW'(e_busy));
    check_eq("mem_rd_en",   RW'(s_rd_en), RW'(e_rd));
    check_eq("mem_wr_en",   RW'(s_wr_en), RW'(e_wr));
    check_eq("mem_addr",    RW'(s_addr),  RW'(e_addr));
    check_eq("mem_wr_data", RW'(s_wdata), RW'(e_wd));
    check_eq("rd_valid",    RW'(s_valid), RW'(e_valid));
    check_eq("wr_done",     RW'(s_done),  RW'(e_done));
    check_eq("rd_data",     s_rdata,      m_rdata);
    if (done_txn) begin
      m_active = 0;
      m_rr     = (m_port + 1) % N;
    end
    if (granted) begin
      m_active = 1; m_issued = 0; m_port = gp; m_wr = wr_en[gp];
      m_addr   = m_wr ? wr_addr[gp] : rd_addr[gp];
      m_wdata  = wdata[gp];
    end
    if (rst) begin
      m_active = 0; m_rr = 0; m_rdata = '0;
    end
    cyc++;
  endtask

  // One clock cycle: apply inputs, observe mid-cycle, check, advance to next negedge.
  task automatic tick();
    drive_inputs();
    #1;
    s_busy = bus.busy; s_rd_en = bus.mem_rd_en; s_wr_en = bus.mem_wr_en;
    s_addr = bus.mem_addr; s_wdata = bus.mem_wr_data;
    s_valid = bus.acc_read_data_valid; s_done = bus.acc_write_done;
    s_rdata = bus.acc_read_data;
    model_step();
    for (int i = L - 1; i > 0; i--) mem_pipe[i] = mem_pipe[i-1];
    mem_pipe[0] = s_rd_en ? mem_pattern(s_addr) : rand_rw();
    @(negedge clk);
  endtask

  task automatic auto_req(input int pct);
    int kind;
    for (int p = 0; p < N; p++) begin
      if (e_done[p])  wr_en[p] = 1'b0;
      if (e_valid[p]) rd_en[p] = 1'b0;
      if (!rd_en[p] && !wr_en[p] && int'($urandom_range(99)) < pct) begin
        kind       = int'($urandom_range(2));
        rd_addr[p] = AW'($urandom);
        wr_addr[p] = AW'($urandom);
        wdata[p]   = $urandom;
        rd_en[p]   = (kind != 1);
        wr_en[p]   = (kind != 0);
      end
    end
  endtask

  task automatic drain();
    rd_en = '0; wr_en = '0; cpu = 1'b0;
    repeat (8) tick();
  endtask

  int pcyc[$];
  int pport[$];

  initial begin
    rst = 1'b1; cpu = 1'b0; rd_en = '0; wr_en = '0;
    for (int p = 0; p < N; p++) begin rd_addr[p] = '0; wr_addr[p] = '0; wdata[p] = '0; end
    for (int i = 0; i < L; i++) mem_pipe[i] = '0;
    m_active = 0; m_issued = 0; m_wr = 0; m_port = 0; m_rr = 0; m_resp_at = 0; cyc = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; e_valid = '0; e_done = '0;
    drive_inputs();
    repeat (3) @(negedge clk);

    tick();
    check_eq("rst_busy",  RW'(s_busy), RW'(1'b0));
    check_eq("rst_rdata", s_rdata,     '0);
    rst = 1'b0;
    tick();

    // single write, port 0
    wr_en[0] = 1'b1; wr_addr[0] = 16'h5000; wdata[0] = 32'h5;
    tick();
    tick();
    check_eq("wr_issue_en",   RW'(s_wr_en), RW'(1'b1));
    check_eq("wr_issue_addr", RW'(s_addr),  RW'(16'h5000));
    check_eq("wr_issue_data", RW'(s_wdata), RW'(32'h5));
    tick();
    check_eq("wr_done_t2", RW'(s_done), RW'(2'b01));
    wr_en[0] = 1'b0;
    tick();
    check_eq("wr_done_t3", RW'(s_done), RW'(2'b00));

    // single read, port 1
    rd_en[1] = 1'b1; rd_addr[1] = 16'h1010;
    tick();
    tick();
    check_eq("rd_issue_en",   RW'(s_rd_en), RW'(1'b1));
    check_eq("rd_issue_addr", RW'(s_addr),  RW'(16'h1010));
    tick();
    check_eq("rd_valid_t2", RW'(s_valid), RW'(2'b00));
    tick();
    check_eq("rd_valid_t3", RW'(s_valid), RW'(2'b10));
    check_eq("rd_data_a5",  s_rdata,      {64{8'hA5}});
    rd_en[1] = 1'b0;
    tick();

    // fairness: both ports write continuously
    wr_en = 2'b11; wr_addr[0] = 16'h0100; wr_addr[1] = 16'h0200;
    for (int i = 0; i < 14; i++) begin
      for (int p = 0; p < N; p++) if (e_done[p]) wdata[p] = $urandom;
      tick();
      if (s_done != '0) begin
        pcyc.push_back(cyc);
        pport.push_back(s_done[1] ? 1 : 0);
      end
    end
    check_eq("fair_count", RW'(pcyc.size()), RW'(4));
    for (int i = 0; i < pcyc.size() && i < 4; i++) begin
      check_eq("fair_port", RW'(pport[i]), RW'(i % 2));
      if (i > 0) check_eq("fair_gap", RW'(pcyc[i] - pcyc[i-1]), RW'(3));
    end
    drain();

    // CPU holds memory for 4 cycles starting at ISSUE
    wr_en[0] = 1'b1; wr_addr[0] = 16'h2468; wdata[0] = $urandom;
    tick();
    cpu = 1'b1;
    repeat (4) begin
      tick();
      check_eq("cpu_hold_en", RW'(s_wr_en | s_rd_en), RW'(1'b0));
    end
    cpu = 1'b0;
    tick();
    check_eq("cpu_rel_en",   RW'(s_wr_en), RW'(1'b1));
    check_eq("cpu_rel_addr", RW'(s_addr),  RW'(16'h2468));
    tick();
    check_eq("cpu_rel_done", RW'(s_done), RW'(2'b01));
    wr_en[0] = 1'b0;
    tick();

    // reset during WAIT of a port-1 read
    rd_en[1] = 1'b1; rd_addr[1] = AW'($urandom);
    tick();
    tick();
    check_eq("rstw_issue", RW'(s_rd_en), RW'(1'b1));
    wr_en[0] = 1'b1; wr_addr[0] = 16'h0BEE; wdata[0] = $urandom;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_eq("rstw_valid", RW'(s_valid), RW'(2'b00));
    check_eq("rstw_busy",  RW'(s_busy),  RW'(1'b0));
    check_eq("rstw_rden",  RW'(s_rd_en), RW'(1'b0));
    check_eq("rstw_rdata", s_rdata,      '0);
    tick();
    check_eq("rstw_grant0_en",   RW'(s_wr_en), RW'(1'b1));
    check_eq("rstw_grant0_addr", RW'(s_addr),  RW'(16'h0BEE));
    repeat (8) begin auto_req(0); tick(); end

    // dual request on port 0: write first, then the read
    rd_en[0] = 1'b1; wr_en[0] = 1'b1; rd_addr[0] = 16'h0420; wr_addr[0] = 16'h0840;
    wdata[0] = $urandom;
    tick();
    tick();
    check_eq("dual_wr_en",   RW'(s_wr_en), RW'(1'b1));
    check_eq("dual_wr_rd",   RW'(s_rd_en), RW'(1'b0));
    check_eq("dual_wr_addr", RW'(s_addr),  RW'(16'h0840));
    tick();
    check_eq("dual_done",    RW'(s_done),  RW'(2'b01));
    check_eq("dual_novalid", RW'(s_valid), RW'(2'b00));
    wr_en[0] = 1'b0;
    tick();
    tick();
    check_eq("dual_rd_en",   RW'(s_rd_en), RW'(1'b1));
    check_eq("dual_rd_addr", RW'(s_addr),  RW'(16'h0420));
    tick();
    tick();
    check_eq("dual_valid", RW'(s_valid), RW'(2'b01));
    rd_en[0] = 1'b0;
    tick();

    // randomized traffic with CPU contention and occasional resets
    for (int i = 0; i < 3000; i++) begin
      auto_req(35);
      cpu = ($urandom_range(99) < 20);
      rst = ($urandom_range(999) < 3);
      tick();
    end
    rst = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/acc_mem_arbiter.md
# acc_mem_arbiter

Shared Data Memory port arbiter serving the memory requests of all accelerator control units. It accepts level-held read/write requests from `NUM_ACC` accelerators and serializes them round-robin onto the single accelerator-side Data Memory port. It yields to CPU memory traffic and returns a one-cycle `read_data_valid` or `write_done` pulse to the requester. It is the responder end of the accelerator read-enable / write-enable handshake.

## Interface
Parameters:
- `NUM_ACC`, 2: number of accelerator requesters (≥1).
- `ADDR_SIZE`, 16: memory address width.
- `READ_DATA_SIZE`, 512: read data width.
- `WRITE_DATA_SIZE`, 32: write data width.
- `MEM_READ_LATENCY`, 1: cycles from the `mem_rd_en` cycle to valid `mem_rd_data` (≥1).

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `cpu_mem_busy` in 1: CPU owns memory this cycle; the arbiter must not drive enables.
- `acc_read_en` in NUM_ACC: per-port read request, held until the valid pulse.
- `acc_read_addr` in NUM_ACC*ADDR_SIZE: port i at bits [i*ADDR_SIZE +: ADDR_SIZE].
- `acc_write_en` in NUM_ACC: per-port write request, held until the done pulse.
- `acc_write_addr` in NUM_ACC*ADDR_SIZE: packed per port.
- `acc_write_data` in NUM_ACC*WRITE_DATA_SIZE: packed per port.
- `acc_read_data` out READ_DATA_SIZE: captured read data, broadcast to all ports.
- `acc_read_data_valid` out NUM_ACC: one-cycle pulse to the served reader.
- `acc_write_done` out NUM_ACC: one-cycle pulse to the served writer.
- `mem_addr` out ADDR_SIZE: memory address.
- `mem_rd_en` out 1: memory read strobe.
- `mem_wr_en` out 1: memory write strobe.
- `mem_wr_data` out WRITE_DATA_SIZE: memory write data.
- `mem_rd_data` in READ_DATA_SIZE: memory read data.
- `busy` out 1: high in every state except IDLE.

## Operation
- Registered FSM with states IDLE, ISSUE, WAIT and RESP. Holding registers: `sel_port`, `sel_is_write`, `sel_addr`, `sel_wdata`, `rr_ptr`, `lat_cnt`, `rd_buf`.
- **IDLE:**
  - Port i is pending if `acc_read_en[i]` or `acc_write_en[i]` is high.
  - If `cpu_mem_busy` is 0 and any port is pending, grant the first pending port scanning from `rr_ptr` upward, wrapping modulo `NUM_ACC`.
  - Latch that port's address, data and request type, then go to ISSUE.
  - If the granted port asserts both read and write, the write is served. The read stays pending for a later grant.
- **ISSUE:**
  - If `cpu_mem_busy` is 1, stay in ISSUE with both enables low.
  - Otherwise drive `mem_addr`=`sel_addr` with `mem_wr_en`=1 (and `mem_wr_data`=`sel_wdata`) or `mem_rd_en`=1 for exactly this cycle.
  - A write goes to RESP. A read loads `lat_cnt`=`MEM_READ_LATENCY` and goes to WAIT.
- **WAIT:**
  - Decrement `lat_cnt` each cycle.
  - In the cycle where `lat_cnt`==1, capture `mem_rd_data` into `rd_buf` and go to RESP.
- **RESP:**
  - Pulse `acc_write_done[sel_port]` for a write, or `acc_read_data_valid[sel_port]` for a read, for exactly one cycle.
  - Set `rr_ptr` = (`sel_port`+1) mod `NUM_ACC` and go to IDLE.
- `acc_read_data` always equals `rd_buf`. It holds its value until the next read capture.
- Requests are sampled only in IDLE. A request dropped after grant is ignored: the transaction completes and the pulse is still issued.
- The memory outputs `mem_addr`, `mem_wr_data` are 0 whenever no enable is high.
- Reset values: all outputs 0, `rd_buf` 0, `rr_ptr` 0, state IDLE.
- Reset mid-transaction aborts with no pulse, and the enables are low from the next edge.

## Timing
- A request first seen in IDLE at cycle T, with no CPU contention, completes as follows:
  - Write: `mem_wr_en` at T+1, `acc_write_done` at T+2.
  - Read: `mem_rd_en` at T+1, `acc_read_data_valid` at T+2+`MEM_READ_LATENCY`. This is T+3 for the default.
- Each cycle `cpu_mem_busy` is held in ISSUE delays completion by one cycle. `cpu_mem_busy` has no effect in WAIT or RESP.
- The requester may present a new request in the cycle after the pulse. The arbiter sees it in IDLE at T+3 for a write.
- There is no back-to-back grant. Every transaction passes through IDLE, so the minimum write-to-write spacing is 3 cycles.
- At most one pulse is high across all ports in any cycle.

## Test plan
- Single write: port 0 write addr 0x5000 data 0x5 -> `mem_wr_en`=1, `mem_addr`=0x5000, `mem_wr_data`=0x5 at T+1. `acc_write_done`=2'b01 at T+2 only.
- Single read: port 1 read addr 0x1010, memory returns pattern 0xA5…A5 one cycle after the strobe -> `acc_read_data_valid`=2'b10 at T+3 and `acc_read_data`=0xA5…A5. Port 0 gets no pulse.
- Fairness: both ports issue continuous writes with `rr_ptr`=0 -> grants alternate 0,1,0,1. Done pulses are exactly 3 cycles apart.
- CPU contention: `cpu_mem_busy` high for 4 cycles starting at the ISSUE cycle -> no enable for those 4 cycles. `mem_wr_en` on the 5th cycle, done pulse one cycle later.
- Reset mid-read: assert `rst` during WAIT -> no `acc_read_data_valid` pulse, all outputs 0 after the edge. The next grant goes to port 0.
- Dual request: port 0 asserts both read and write -> the write is served first and the read is served on the following grant.
